// File: rtl/division_seq_param_if.sv
// Request/result bundle for the sequential divider.
// master = requester (drives operands and start), slave = divider.
interface division_seq_param_if #(
  parameter int DW = 8
);
  logic          start;
  logic          signed_mode;
  logic [DW-1:0] Dividendo;
  logic [DW-1:0] Divisor;
  logic          busy;
  logic          ready;
  logic [DW-1:0] Cosiente;
  logic [DW-1:0] Residuo;
  logic          div_zero;

  modport master (
    output start, signed_mode, Dividendo, Divisor,
    input  busy, ready, Cosiente, Residuo, div_zero
  );

  modport slave (
    input  start, signed_mode, Dividendo, Divisor,
    output busy, ready, Cosiente, Residuo, div_zero
  );
endinterface

// File: rtl/division_seq_param.sv
// Fixed-latency restoring divider, signed or unsigned, DW-bit operands.
// Operands are reduced to magnitudes at capture, DW shift-subtract steps run
// in DIV, and FIX restores signs and handles divide-by-zero. Result is ready
// DW+1 edges after the accepting edge regardless of operand values.
module division_seq_param #(
  parameter int DW = 8
) (
  input  logic               clk,
  input  logic               rst,
  division_seq_param_if.slave bus
);
  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {IDLE, DIV, FIX} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [DW-1:0] quo_q;     // dividend bits shift out the top, quotient bits in the bottom
  logic [DW:0]   rem_q;     // partial remainder, extra bit carries the subtract sign
  logic [DW-1:0] dvs_q;     // divisor magnitude
  logic [DW-1:0] dvd_raw_q; // raw dividend, returned as remainder on divide-by-zero
  logic          neg_quo_q;
  logic          neg_rem_q;
  logic          zero_q;

  logic          busy_q;
  logic          ready_q;
  logic          dz_q;
  logic [DW-1:0] cos_q;
  logic [DW-1:0] res_q;

  logic [DW-1:0] a_abs_d;
  logic [DW-1:0] b_abs_d;
  logic [DW:0]   rem_sh_d;
  logic [DW:0]   diff_d;

  // Operand magnitudes at capture, and one trial subtraction per DIV step.
  // -2^(DW-1) has magnitude 2^(DW-1), which still fits as an unsigned DW-bit value.
  always_comb begin
    a_abs_d  = (bus.signed_mode && bus.Dividendo[DW-1]) ? -bus.Dividendo : bus.Dividendo;
    b_abs_d  = (bus.signed_mode && bus.Divisor[DW-1])   ? -bus.Divisor   : bus.Divisor;
    rem_sh_d = {rem_q[DW-1:0], quo_q[DW-1]};
    diff_d   = rem_sh_d - {1'b0, dvs_q};
  end

  // Control FSM with datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      dvd_raw_q <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      zero_q    <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
      dz_q      <= 1'b0;
      cos_q     <= '0;
      res_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            quo_q     <= a_abs_d;
            rem_q     <= '0;
            dvs_q     <= b_abs_d;
            dvd_raw_q <= bus.Dividendo;
            neg_quo_q <= bus.signed_mode & (bus.Dividendo[DW-1] ^ bus.Divisor[DW-1]);
            neg_rem_q <= bus.signed_mode & bus.Dividendo[DW-1];
            zero_q    <= (bus.Divisor == '0);
            cnt_q     <= CW'(DW);
            busy_q    <= 1'b1;
            ready_q   <= 1'b0;
            state_q   <= DIV;
          end
        end
        DIV: begin
          if (!diff_d[DW]) begin
            rem_q <= diff_d;
            quo_q <= {quo_q[DW-2:0], 1'b1};
          end else begin
            rem_q <= rem_sh_d;
            quo_q <= {quo_q[DW-2:0], 1'b0};
          end
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= FIX;
        end
        FIX: begin
          cos_q   <= zero_q ? '1 : (neg_quo_q ? -quo_q : quo_q);
          res_q   <= zero_q ? dvd_raw_q : (neg_rem_q ? -rem_q[DW-1:0] : rem_q[DW-1:0]);
          dz_q    <= zero_q;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.ready    = ready_q;
  assign bus.Cosiente = cos_q;
  assign bus.Residuo  = res_q;
  assign bus.div_zero = dz_q;
endmodule

// File: doc/division_seq_param.md
DIVISION_SEQ_PARAM -- requirements
Module: division_seq_param

Interface
REQ-001 The block SHALL expose parameter DW, default 8, operand/result width in bits (legal range 2..32).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  request pulse; sampled on a rising clk edge.
REQ-005 signed_mode  input  1  0 = unsigned, 1 = two's-complement; sampled with start.
REQ-006 Dividendo  input  DW  dividend; sampled with start.
REQ-007 Divisor  input  DW  divisor; sampled with start.
REQ-008 busy  output  1  division in progress.
REQ-009 ready  output  1  result valid; level signal.
REQ-010 Cosiente  output  DW  quotient, registered.
REQ-011 Residuo  output  DW  remainder, registered.
REQ-012 div_zero  output  1  last accepted operation had Divisor == 0.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, DIV and FIX.
REQ-014 In IDLE, start=1 at edge t0 SHALL capture operands, signed_mode and the operand magnitudes, load a step counter with DW, set busy=1, clear ready, and move to DIV.
REQ-015 DIV SHALL perform one restoring shift-subtract step per edge, using a DW+1-bit partial remainder, for DW edges (t0+1 .. t0+DW), then move to FIX.
REQ-016 At edge t0+DW+1, FIX SHALL apply sign correction, write Cosiente, Residuo and div_zero, set ready=1, clear busy, and return to IDLE.
REQ-017 Fixed latency: ready SHALL rise exactly DW+1 edges after the accepting edge, independent of operand values.
REQ-018 ready, Cosiente, Residuo and div_zero SHALL hold stable until the next start is accepted.
REQ-019 start while busy=1 SHALL be ignored and SHALL NOT alter captured operands or timing.
REQ-020 start in IDLE while ready=1 SHALL be accepted; ready falls at that same edge.
REQ-021 Unsigned mode: Cosiente = floor(Dividendo/Divisor); Residuo = Dividendo mod Divisor.
REQ-022 Signed mode: the quotient SHALL truncate toward zero; the remainder SHALL take the sign of the dividend; the identity Dividendo = Cosiente*Divisor + Residuo SHALL hold modulo 2^DW.
REQ-023 Signed -2^(DW-1) / -1 SHALL yield Cosiente = -2^(DW-1) (wrap), Residuo = 0, div_zero = 0.
REQ-024 Divisor == 0 SHALL still take DW+1 cycles, then give div_zero=1, Cosiente = all ones, Residuo = Dividendo, in either mode.
REQ-025 A Dividendo of 0 SHALL yield Cosiente=0, Residuo=0.

Reset
REQ-026 rst=1 SHALL asynchronously force state IDLE, counter 0, busy=0, ready=0, Cosiente=0, Residuo=0 and div_zero=0.
REQ-027 rst asserted mid-operation SHALL abort the division; no ready pulse SHALL follow the deassertion.
REQ-028 The first start accepted after rst deasserts SHALL behave exactly as from power-up.

Verification (DW=4)
REQ-029 Unsigned: Dividendo=4'b1111, Divisor=4'b0011, start at t0 -> ready=1 after edge t0+5, Cosiente=4'b0101, Residuo=4'b0000, div_zero=0.
REQ-030 Signed: -7 (4'b1001) / 2 (4'b0010) -> Cosiente=4'b1101 (-3), Residuo=4'b1111 (-1).
REQ-031 Signed: -8 (4'b1000) / -1 (4'b1111) -> Cosiente=4'b1000, Residuo=4'b0000, div_zero=0.
REQ-032 Divide by zero: 9 / 0 -> div_zero=1, Cosiente=4'b1111, Residuo=4'b1001, ready after edge t0+5.
REQ-033 Busy and reset: start pulses again at t0+2 -> ignored, result still 15/3 at t0+5. In a separate run, rst pulses at t0+3 -> busy=0 and ready=0 immediately, ready stays 0 through t0+10.
